// File: rtl/console_pkg.sv
// Shared types and constants for the console UART blocks.
package console_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;   // 100 MHz / 115200 baud

    // Receive (framing) FSM; PARITY is only reachable in 8E1 builds
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Holding register / four-phase handshake FSM
    typedef enum logic [1:0] {
        EMPTY,
        FULL,
        WAIT_ACK_LOW
    } hs_state_t;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous bit.
// Resets to 1 so an idle-high line does not look like an edge after reset.
module bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_console_rx.sv
// UART receiver feeding the console byte stream with a four-phase ack handshake.
// Default build: 8N1. Define UART_CONSOLE_RX_PARITY_EN for 8E1 with a
// PARITY_ERR pulse output.
module uart_console_rx
    import console_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RX,
    output logic [7:0] CONSOLE_IN,
    output logic       CONSOLE_IN_valid,
    input  logic       CONSOLE_IN_ack,
    output logic       FRAME_ERR,
    output logic       OVERRUN
`ifdef UART_CONSOLE_RX_PARITY_EN
    ,
    output logic       PARITY_ERR
`endif
);

    localparam int            BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]        BIT_IDX_LAST = 3'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_prev;
    rx_state_t            rx_state, rx_next;
    hs_state_t            hs_state, hs_next;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    logic start_edge;
    logic half_done;
    logic bit_done;
    logic stop_sample;
    logic frame_good;
    logic frame_bad;
    logic parity_bad;

    bit_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx_sync (
        .clk    (CLK),
        .reset_n(RESET),
        .d      (RX),
        .q      (rx_s)
    );

    // Receive FSM state register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rx_state <= IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    // Receive FSM next-state decode
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:   if (start_edge) rx_next = START;
            START:  if (half_done)  rx_next = rx_s ? IDLE : DATA;
            DATA: begin
                if (bit_done && bit_cnt == BIT_IDX_LAST) begin
`ifdef UART_CONSOLE_RX_PARITY_EN
                    rx_next = PARITY;
`else
                    rx_next = STOP;
`endif
                end
            end
            PARITY: if (bit_done) rx_next = STOP;
            STOP:   if (bit_done) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    // Receive FSM sample strobes and frame verdicts
    always_comb begin
        // A start needs a 1->0 edge, so a held-low break cannot retrigger
        start_edge  = (rx_state == IDLE) && rx_prev && !rx_s;
        half_done   = (baud_cnt == HALF_LAST);
        bit_done    = (baud_cnt == BIT_LAST);
        stop_sample = (rx_state == STOP) && bit_done;
        frame_bad   = stop_sample && !rx_s;
        frame_good  = stop_sample && rx_s && !parity_bad;
    end

    // Baud and bit counters plus edge-detect history
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rx_prev  <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            rx_prev <= rx_s;
            case (rx_state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
                START:   baud_cnt <= half_done ? '0 : baud_cnt + BAUD_W'(1);
                default: baud_cnt <= bit_done  ? '0 : baud_cnt + BAUD_W'(1);
            endcase
            // Wraps 7 -> 0 as the last data bit is taken
            if (rx_state == DATA && bit_done) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // Shift data bits in LSB first
    always_ff @(posedge CLK) begin
        if (rx_state == DATA && bit_done) begin
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
        end
    end

`ifdef UART_CONSOLE_RX_PARITY_EN
    logic parity_bad_q;

    // Latch the even-parity check; reported and applied at the stop sample
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            parity_bad_q <= 1'b0;
        end else if (rx_state == PARITY && bit_done) begin
            parity_bad_q <= rx_s ^ (^shift_reg);
        end
    end

    assign parity_bad = parity_bad_q;

    // Parity error pulse coincides with the stop-bit verdict
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            PARITY_ERR <= 1'b0;
        end else begin
            PARITY_ERR <= stop_sample && parity_bad_q;
        end
    end
`else
    assign parity_bad = 1'b0;
`endif

    // Handshake FSM state register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            hs_state <= EMPTY;
        end else begin
            hs_state <= hs_next;
        end
    end

    // Handshake FSM next-state decode; only EMPTY accepts a new byte
    always_comb begin
        hs_next = hs_state;
        case (hs_state)
            EMPTY:        if (frame_good)      hs_next = FULL;
            FULL:         if (CONSOLE_IN_ack)  hs_next = WAIT_ACK_LOW;
            WAIT_ACK_LOW: if (!CONSOLE_IN_ack) hs_next = EMPTY;
            default:      hs_next = EMPTY;
        endcase
    end

    // Handshake FSM outputs: valid spans FULL and WAIT_ACK_LOW
    always_comb begin
        CONSOLE_IN_valid = (hs_state != EMPTY);
    end

    // Holding register and error pulses
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            CONSOLE_IN <= '0;
            FRAME_ERR  <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            FRAME_ERR <= frame_bad;
            OVERRUN   <= frame_good && (hs_state != EMPTY);
            if (frame_good && hs_state == EMPTY) begin
                CONSOLE_IN <= shift_reg;
            end
        end
    end

endmodule

// File: doc/uart_console_rx.md
Name: uart_console_rx

Overview:
- Serial UART receiver that produces the console input byte stream for the Wrapper.
- Deserialises 8N1 frames from the board RX pin.
- Presents each byte on CONSOLE_IN with CONSOLE_IN_valid.
- Holds each byte until the Wrapper completes a four-phase ack handshake.
- Sits between the top-level RX pin and Wrapper's CONSOLE_IN / CONSOLE_IN_valid / CONSOLE_IN_ack ports.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200 baud); must be >= 4.
- SYNC_STAGES, 2, flip-flop stages synchronising RX into the CLK domain; must be >= 2.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-low reset.
- RX  in  1  asynchronous serial input; idle high.
- CONSOLE_IN  out  8  received byte; stable while CONSOLE_IN_valid is high.
- CONSOLE_IN_valid  out  1  byte available.
- CONSOLE_IN_ack  in  1  consumer acknowledge (four-phase).
- FRAME_ERR  out  1  one-cycle pulse: stop bit sampled low.
- OVERRUN  out  1  one-cycle pulse: frame completed while the holding register was occupied; that byte is dropped.

Behaviour:
- Reset (RESET=0 at a CLK edge):
  - All outputs go to 0, synchroniser flops go to 1, and both FSMs go to their idle state.
  - Reset mid-frame or mid-handshake abandons the frame or byte.
- Receive FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a synchronised 1->0 transition, go to START and clear the bit counter.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If low, go to DATA. If high (glitch), go to IDLE with no error.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 bits (bit index 0..7), shifted into a shift register.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If high: frame good; hand off to the holding register (see below).
    - If low: FRAME_ERR=1 for one cycle, byte discarded.
  - STOP always returns to IDLE. IDLE requires RX high before a new start is accepted, so a break (RX held low) produces one error, not repeated frames.
- Holding register / handshake states: EMPTY, FULL, WAIT_ACK_LOW.
  - EMPTY + good frame: CONSOLE_IN <= byte; CONSOLE_IN_valid=1 on the next cycle; go to FULL.
  - FULL: hold CONSOLE_IN_valid=1 and CONSOLE_IN constant. When CONSOLE_IN_ack=1, go to WAIT_ACK_LOW with valid still high.
  - WAIT_ACK_LOW: when CONSOLE_IN_ack=0, drop CONSOLE_IN_valid in that cycle's update and go to EMPTY. CONSOLE_IN keeps its last value.
  - Good frame while not EMPTY: OVERRUN pulses; the held byte is unchanged.
  - Good frame in the same cycle as the WAIT_ACK_LOW -> EMPTY transition: counts as overrun. Only EMPTY accepts.
  - ack high while in EMPTY: ignored.
- Latency: CONSOLE_IN_valid rises 1 cycle after the stop-bit sample point, i.e. about 9.5 bit periods + SYNC_STAGES + 1 cycles after the start edge.
- Counters:
  - Baud counter: $clog2(CLKS_PER_BIT) bits, reloads on wrap.
  - Bit counter: 3 bits, wraps 7 -> 0 on leaving DATA.
- Receiver and handshake run concurrently: the next frame can be received while a byte is held.

Optional Feature:
- Macro: UART_CONSOLE_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1. A PARITY state sits between DATA and STOP.
  - The sampled parity bit must equal XOR of the data bits (even parity).
  - On mismatch, the frame is still run through STOP, then discarded, and PARITY_ERR (extra 1-bit output port, one-cycle pulse) asserts at the stop sample.
  - A frame with both parity and stop errors pulses both outputs.
- Undefined: 8N1, no PARITY state, no PARITY_ERR port.

Decomposition:
- Shared package console_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - hs_state_t enum (EMPTY, FULL, WAIT_ACK_LOW).
  - Constants: DATA_BITS=8, default CLKS_PER_BIT.
- One natural sub-module: bit_sync (SYNC_STAGES-deep synchroniser, reset value 1), reused later by the console TX side and PB debouncing.

Test Plan (CLKS_PER_BIT=8 for speed):
- Frame 0x50 ('P'), bench acks 3 cycles after valid, releases ack 2 cycles later -> CONSOLE_IN=0x50, valid high until the cycle after ack falls, no error pulses.
- Frames 0x41 then 0x0D sent back-to-back, bench acks promptly -> two handshakes in order, CONSOLE_IN=0x41 then 0x0D.
- Frame 0x41 with the bench never acking, then frame 0x42 -> CONSOLE_IN stays 0x41, OVERRUN pulses once at the second stop sample; after ack, valid drops and 0x42 never appears.
- Frame 0x55 with stop bit forced low, then RX held low for 20 bit periods -> exactly one FRAME_ERR pulse, valid stays 0; a subsequent 0x33 frame is received correctly.
- 2-cycle low glitch on idle RX -> START rejects it, no valid, no errors. RESET low mid-DATA -> outputs 0; the next full 0xA5 frame is received correctly.
- UART_CONSOLE_RX_PARITY_EN defined:
  - Frame 0x07 with parity bit 1 -> accepted.
  - Frame 0x07 with parity bit 0 -> PARITY_ERR pulse, no valid.
